// File: rtl/lut_load_sequencer.sv
// Serial loader for the LUT macro: bytes in over valid/ready, shifted MSB-first onto d/cs_n; single-step rotations on request.
// Latency: an accepted byte drives cs_n low from the accept edge for 8 cycles; done pulses one cycle after the last sampling edge.
// Backpressure: in_ready only in IDLE or on the last bit of a byte (back-to-back, no gap); flush forces it low.
module lut_load_sequencer #(
  parameter int TABLE_BITS = 32,
  parameter int ROT_LEN    = 8,
  localparam int NBYTES    = TABLE_BITS / 8,
  localparam int NROT      = TABLE_BITS / ROT_LEN,
  localparam int RW        = (NROT > 1) ? $clog2(NROT) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          rot_req,
  output logic          rot_ack,
  input  logic          flush,
  output logic          lut_d,
  output logic          lut_cs_n,
  output logic          lut_rot_n,
  output logic          busy,
  output logic          loaded,
  output logic          done,
  output logic [RW-1:0] rot_pos
);

  localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);
  localparam logic [RW-1:0] ROT_LAST  = RW'(NROT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ROT   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      buf_q, buf_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [RW-1:0]   rot_pos_q, rot_pos_d;
  logic            loaded_q, loaded_d;
  logic            done_q, done_d;
  logic            rot_ack_q, rot_ack_d;
  logic            lut_cs_n_q, lut_cs_n_d;
  logic            lut_rot_n_q, lut_rot_n_d;
  logic            busy_q, busy_d;

  logic            accept;
  logic            rot_go;
  logic            last_bit;
  logic            last_byte;
  logic [RW-1:0]   rot_pos_inc;

  // The last bit of a byte is on the pins, so a follow-on byte can be taken without a gap cycle.
  assign in_ready  = ~flush & ((state_q == ST_IDLE) |
                               ((state_q == ST_SHIFT) & (bit_cnt_q == 3'd7)));
  assign accept    = in_valid & in_ready;
  assign last_bit  = (state_q == ST_SHIFT) & (bit_cnt_q == 3'd7);
  assign last_byte = (byte_cnt_q == BYTE_LAST);
  // A load always wins over a rotation; rotations only on a complete, byte-aligned table.
  assign rot_go    = (state_q == ST_IDLE) & ~flush & ~accept & rot_req &
                     loaded_q & (byte_cnt_q == '0);
  assign rot_pos_inc = (rot_pos_q == ROT_LAST) ? '0 : rot_pos_q + RW'(1);

  // State and datapath registers; async reset returns every pin to its idle level at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      rot_pos_q   <= '0;
      loaded_q    <= 1'b0;
      done_q      <= 1'b0;
      rot_ack_q   <= 1'b0;
      lut_cs_n_q  <= 1'b1;
      lut_rot_n_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      rot_pos_q   <= rot_pos_d;
      loaded_q    <= loaded_d;
      done_q      <= done_d;
      rot_ack_q   <= rot_ack_d;
      lut_cs_n_q  <= lut_cs_n_d;
      lut_rot_n_q <= lut_rot_n_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state selection; flush overrides everything and lands in IDLE.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept)      state_d = ST_SHIFT;
          else if (rot_go) state_d = ST_ROT;
        end
        ST_SHIFT: begin
          if (bit_cnt_q == 3'd7) state_d = accept ? ST_SHIFT : ST_IDLE;
        end
        ST_ROT:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Next values of counters, flags and pin registers, so the LUT pins come straight from flops.
  always_comb begin
    buf_d       = buf_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    rot_pos_d   = rot_pos_q;
    loaded_d    = loaded_q;
    done_d      = 1'b0;
    rot_ack_d   = 1'b0;
    lut_cs_n_d  = 1'b1;
    lut_rot_n_d = 1'b1;
    // The LUT rotates on the edge that ends the ROT cycle, even if a flush arrives with it.
    if (state_q == ST_ROT) rot_pos_d = rot_pos_inc;
    if (flush) begin
      buf_d      = '0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      loaded_d   = 1'b0;
    end else begin
      if (state_q == ST_SHIFT) begin
        // Shifting in zeros leaves the buffer (and so lut_d) at 0 once a byte is fully out.
        buf_d     = {buf_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (last_bit) begin
          byte_cnt_d = last_byte ? '0 : byte_cnt_q + BW'(1);
          if (last_byte) begin
            loaded_d  = 1'b1;
            done_d    = 1'b1;
            rot_pos_d = '0;
          end
        end
      end
      if (accept) begin
        buf_d     = in_data;
        bit_cnt_d = '0;
      end
      if (rot_go) begin
        rot_ack_d   = 1'b1;
        lut_rot_n_d = 1'b0;
      end
    end
    if (state_d == ST_SHIFT) lut_cs_n_d = 1'b0;
    busy_d = (state_d != ST_IDLE);
  end

  assign lut_d     = buf_q[7];
  assign lut_cs_n  = lut_cs_n_q;
  assign lut_rot_n = lut_rot_n_q;
  assign rot_ack   = rot_ack_q;
  assign busy      = busy_q;
  assign loaded    = loaded_q;
  assign done      = done_q;
  assign rot_pos   = rot_pos_q;

endmodule

// File: tb/tb_lut_load_sequencer.sv
// Bench for lut_load_sequencer: random loads/rotations/flushes against a table-level reference model.
// Latency: expected serial bits and done cycles are queued at byte acceptance and popped by a monitor.
// Backpressure: the driver holds in_valid until in_ready; rot_req is held until rot_ack.
module tb_lut_load_sequencer;
  localparam int TABLE_BITS = 32;
  localparam int ROT_LEN    = 8;
  localparam int NBYTES     = TABLE_BITS / 8;
  localparam int NROT       = TABLE_BITS / ROT_LEN;
  localparam int RW         = (NROT > 1) ? $clog2(NROT) : 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          rot_req = 1'b0;
  logic          flush = 1'b0;
  logic          in_ready, rot_ack, lut_d, lut_cs_n, lut_rot_n, busy, loaded, done;
  logic [RW-1:0] rot_pos;

  lut_load_sequencer #(.TABLE_BITS(TABLE_BITS), .ROT_LEN(ROT_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rot_req(rot_req), .rot_ack(rot_ack), .flush(flush), .lut_d(lut_d), .lut_cs_n(lut_cs_n),
    .lut_rot_n(lut_rot_n), .busy(busy), .loaded(loaded), .done(done), .rot_pos(rot_pos)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference state: expected pin bits, expected done cycles, table contents and flags.
  logic       exp_bits[$];
  int         done_q[$];
  logic [7:0] load_bytes[$];
  logic [7:0] ref_tab[NBYTES];
  bit         model_loaded = 0;
  int         model_bytes = 0;
  int         model_rot = 0;
  int         cs_low_cnt = 0;
  int         cs_run = 0;
  int         last_run = 0;

  // Behavioural LUT macro: shift register fed from the pins, rotates by one entry.
  logic [TABLE_BITS-1:0] lut_sr;
  always @(posedge clk) begin
    if (!lut_cs_n) lut_sr <= {lut_sr[TABLE_BITS-2:0], lut_d};
    else if (!lut_rot_n) lut_sr <= {lut_sr[ROT_LEN-1:0], lut_sr[TABLE_BITS-1:ROT_LEN]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_lut(input string tag);
    for (int e = 0; e < NBYTES; e++)
      chk($sformatf("%s lut entry %0d", tag, e), {24'h0, lut_sr[8*e +: 8]}, {24'h0, ref_tab[e]});
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops and compares whenever the DUT shifts, finishes a table or rotates.
  initial begin : monitor
    logic b;
    int t;
    logic [7:0] tmp;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!lut_cs_n) begin
          cs_low_cnt++;
          cs_run++;
          if (exp_bits.size() == 0) chk("shift cycle with no byte pending", 1, 0);
          else begin
            b = exp_bits.pop_front();
            chk("lut_d bit", {31'h0, lut_d}, {31'h0, b});
          end
        end else if (cs_run > 0) begin
          last_run = cs_run;
          cs_run = 0;
        end
        if (done) begin
          if (done_q.size() == 0) chk("unexpected done", 1, 0);
          else begin
            t = done_q.pop_front();
            chk("done cycle", cyc, t);
          end
          chk("loaded at done", {31'h0, loaded}, 1);
          model_loaded = 1;
          model_rot = 0;
          check_lut("after load");
        end
        if (rot_ack || !lut_rot_n) begin
          chk("rotation allowed", {31'h0, (model_loaded && model_bytes == 0 && exp_bits.size() == 0)}, 1);
          chk("rot_ack with rotation", {31'h0, rot_ack}, 1);
          chk("lut_rot_n with rotation", {31'h0, lut_rot_n}, 0);
          tmp = ref_tab[0];
          for (int i = 0; i < NBYTES - 1; i++) ref_tab[i] = ref_tab[i+1];
          ref_tab[NBYTES-1] = tmp;
          model_rot = (model_rot + 1) % NROT;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d);
    bit got = 0;
    in_valid = 1'b1;
    in_data = d;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("in_ready timeout", 0, 1);
    else begin
      for (int i = 7; i >= 0; i--) exp_bits.push_back(d[i]);
      model_bytes = (model_bytes + 1) % NBYTES;
      load_bytes.push_back(d);
      if (load_bytes.size() == NBYTES) begin
        for (int k = 0; k < NBYTES; k++) ref_tab[NBYTES-1-k] = load_bytes[k];
        load_bytes.delete();
        done_q.push_back(cyc + 1 + 8);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 300 && done_q.size() != 0; k++) @(negedge clk);
    if (done_q.size() != 0) begin
      chk("done timeout", 0, 1);
      done_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_table(input logic [7:0] b [NBYTES], input int max_gap);
    int gap;
    for (int i = 0; i < NBYTES; i++) begin
      send_byte(b[i]);
      if (i == 0) chk("loaded during new load", {31'h0, loaded}, {31'h0, model_loaded});
      gap = $urandom_range(0, max_gap);
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    wait_done();
  endtask

  task automatic wait_ack();
    bit got = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (rot_ack) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("rot_ack timeout", 0, 1);
    @(posedge clk);
    #1;
    rot_req = 1'b0;
  endtask

  task automatic do_rot();
    rot_req = 1'b1;
    wait_ack();
    chk("rot_pos after rotation", {{(32-RW){1'b0}}, rot_pos}, model_rot);
    check_lut("after rotation");
  endtask

  task automatic do_flush(input bit offer);
    flush = 1'b1;
    in_valid = offer;
    in_data = 8'hA5;
    @(negedge clk);
    chk("in_ready under flush", {31'h0, in_ready}, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    model_loaded = 0;
    model_bytes = 0;
    load_bytes.delete();
    chk("busy after flush", {31'h0, busy}, 0);
    chk("loaded after flush", {31'h0, loaded}, 0);
    chk("bits pending after flush", exp_bits.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " lut_cs_n"}, {31'h0, lut_cs_n}, 1);
    chk({tag, " lut_rot_n"}, {31'h0, lut_rot_n}, 1);
    chk({tag, " lut_d"}, {31'h0, lut_d}, 0);
    chk({tag, " busy"}, {31'h0, busy}, 0);
    chk({tag, " loaded"}, {31'h0, loaded}, 0);
    chk({tag, " done"}, {31'h0, done}, 0);
    chk({tag, " rot_ack"}, {31'h0, rot_ack}, 0);
    chk({tag, " rot_pos"}, {{(32-RW){1'b0}}, rot_pos}, 0);
    chk({tag, " in_ready"}, {31'h0, in_ready}, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] tab [NBYTES];
    int r, n;
    #12;
    check_reset_vals("in reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Rotation requested before any load and mid-load: held pending until the table completes.
    rot_req = 1'b1;
    fork
      begin
        repeat (20) @(posedge clk);
        #1;
        send_byte(8'h11);
        send_byte(8'h22);
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        send_byte(8'h33);
        send_byte(8'h44);
        in_valid = 1'b0;
        wait_done();
      end
      wait_ack();
    join
    chk("rot_pos after pending ack", {{(32-RW){1'b0}}, rot_pos}, model_rot);

    // Back-to-back reference load.
    tab[0] = 8'h11; tab[1] = 8'h22; tab[2] = 8'h33; tab[3] = 8'h44;
    r = cs_low_cnt;
    load_table(tab, 0);
    chk("cs_n low cycles", cs_low_cnt - r, 32);
    chk("cs_n low run length", last_run, 32);
    chk("loaded after load", {31'h0, loaded}, 1);
    chk("rot_pos after load", {{(32-RW){1'b0}}, rot_pos}, 0);
    chk("sel3 after load", {24'h0, lut_sr[31:24]}, 8'h11);
    chk("sel0 after load", {24'h0, lut_sr[7:0]}, 8'h44);
    do_rot();
    chk("rot_pos after one rotation", {{(32-RW){1'b0}}, rot_pos}, 1);
    chk("sel0 after one rotation", {24'h0, lut_sr[7:0]}, 8'h33);
    chk("sel3 after one rotation", {24'h0, lut_sr[31:24]}, 8'h44);
    repeat (3) do_rot();
    chk("rot_pos after four rotations", {{(32-RW){1'b0}}, rot_pos}, 0);
    chk("sel3 after four rotations", {24'h0, lut_sr[31:24]}, 8'h11);
    chk("sel1 after four rotations", {24'h0, lut_sr[15:8]}, 8'h33);

    // Flush after two bytes with a third byte offered on the flush edge.
    send_byte(8'hC3);
    send_byte(8'h5A);
    repeat (7) @(posedge clk);
    #1;
    do_flush(1);
    foreach (tab[i]) tab[i] = 8'($urandom);
    load_table(tab, 0);

    // Asynchronous reset at bit 4 of byte 2, then a full reload.
    send_byte(8'hF0);
    send_byte(8'h0F);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async reset");
    exp_bits.delete();
    done_q.delete();
    load_bytes.delete();
    model_loaded = 0;
    model_bytes = 0;
    model_rot = 0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after reset", {31'h0, in_ready}, 1);
    chk("rot_pos after reset", {{(32-RW){1'b0}}, rot_pos}, 0);
    foreach (tab[i]) tab[i] = 8'($urandom);
    load_table(tab, 0);

    // Byte and rotation request together in IDLE with a loaded table: the load goes first.
    foreach (tab[i]) tab[i] = 8'($urandom);
    rot_req = 1'b1;
    fork
      load_table(tab, 0);
      wait_ack();
    join
    chk("rot_pos after deferred rotation", {{(32-RW){1'b0}}, rot_pos}, model_rot);
    check_lut("after deferred rotation");

    // Randomised mix of loads (with gaps), rotations and idle flushes.
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 5 || !model_loaded) begin
        foreach (tab[i]) tab[i] = 8'($urandom);
        load_table(tab, (r < 2) ? 12 : 3);
        chk("loaded after random load", {31'h0, loaded}, 1);
        chk("rot_pos after random load", {{(32-RW){1'b0}}, rot_pos}, 0);
      end else if (r < 8) begin
        n = $urandom_range(1, 5);
        repeat (n) do_rot();
      end else begin
        do_flush($urandom_range(0, 1) == 1);
      end
    end

    repeat (5) @(posedge clk);
    chk("bits left unshifted", exp_bits.size(), 0);
    chk("done events outstanding", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lut_load_sequencer.md
# lut_load_sequencer

Controller for the serial-load LUT macro. It accepts configuration bytes over a valid/ready handshake and serialises each byte MSB-first onto the LUT's shift-register pins (`d`, `cs_n`). It tracks when a full table has been written and issues single-step rotations (`rot_n`) on request. It sits between the tile's pin-level command decoder and the LUT instance, and drives the LUT's data, chip-select and rotate pins from registered outputs on the shared clock.

## Interface
- `TABLE_BITS`, 32: LUT shift-register length (2^IN_WIDTH × OUT_WIDTH); must be a multiple of 8 and of `ROT_LEN`.
- `ROT_LEN`, 8: bits moved per LUT rotation step.
- `NBYTES` (localparam) = TABLE_BITS/8. `NROT` (localparam) = TABLE_BITS/ROT_LEN. `RW` (localparam) = max(1, clog2(NROT)).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  configuration byte present.
- `in_data`  in  8  configuration byte, shifted MSB first.
- `in_ready`  out  1  byte accepted on an edge where `in_valid & in_ready`.
- `rot_req`  in  1  level rotation request, held until `rot_ack`.
- `rot_ack`  out  1  one-cycle pulse: rotation issued.
- `flush`  in  1  synchronous abort of a partial load.
- `lut_d`  out  1  to LUT `d`.
- `lut_cs_n`  out  1  to LUT `cs_n`; low = shift.
- `lut_rot_n`  out  1  to LUT `rot_n`; low = rotate.
- `busy`  out  1  state ≠ IDLE.
- `loaded`  out  1  a complete table has been written since reset or flush.
- `done`  out  1  one-cycle pulse: last bit of the table has been shifted.
- `rot_pos`  out  RW  rotation steps applied since last load, mod NROT.

## Operation
- States: IDLE, SHIFT, ROT.
- Registers: 8-bit shift buffer, 3-bit bit count, byte count (0..NBYTES-1), `rot_pos`.
- Reset values: state = IDLE; `lut_cs_n` = `lut_rot_n` = 1; `lut_d` = 0; `busy` = `loaded` = `done` = `rot_ack` = 0; `rot_pos` = 0; counters = 0. `in_ready` = 1 during reset.
- `in_ready` = (state == IDLE) | (state == SHIFT & bit count == 7).
- IDLE, on an accept: buffer ← `in_data`, bit count ← 0, go to SHIFT.
- IDLE, no accept, `rot_req`: allowed only when byte count == 0 and `loaded` = 1. Go to ROT.
- IDLE, both a byte accept and `rot_req`: the load wins; the rotation stays pending.
- IDLE, `rot_req` with `loaded` = 0 or byte count ≠ 0: the request is ignored and remains pending, never acked.
- SHIFT: `lut_cs_n` = 0 and `lut_d` = buffer[7]; buffer shifts left each cycle; 8 cycles per byte.
- SHIFT, on bit 7: byte count increments.
  - If it wraps from NBYTES-1 to 0: `loaded` ← 1, `done` pulses, `rot_pos` ← 0.
  - If a new byte is accepted on the same edge: stay in SHIFT with no gap cycle. Otherwise go to IDLE.
- ROT: one cycle with `lut_rot_n` = 0 and `rot_ack` = 1; `rot_pos` increments mod NROT; return to IDLE.
- `flush` takes priority over every other input in every state:
  - next state = IDLE; byte and bit counts ← 0; `loaded` ← 0; `lut_cs_n` and `lut_rot_n` ← 1.
  - A byte offered on the same edge is not accepted (`in_ready` forced 0 while `flush` = 1).
  - LUT contents are not altered.
- Starting a new load while `loaded` = 1 keeps `loaded` = 1 until the new load's `done`. The table is partially overwritten during the new load; the command decoder owns that risk.
- Table mapping with OUT_WIDTH = 8: byte k (0-based in load order) lands in LUT entry NBYTES-1-k.
- Each rotation moves entry i+1 into entry i, and entry 0 wraps to the top.

## Timing
- All outputs except `in_ready` are registered; `lut_*` never glitch.
- Byte accepted at edge E0: `lut_cs_n` = 0 from E0 to E8. The LUT samples bits 7..0 at edges E1..E8.
- `in_ready` is high in the cycle before E8, so back-to-back bytes are accepted at E8.
- Full table: 8·NBYTES shift cycles. `done` and `loaded` are high in the cycle after the final sampling edge.
- Rotation: `rot_req` seen in IDLE at edge R0 → `lut_rot_n` = 0 for exactly one cycle (R0 to R1); the LUT rotates at R1. `rot_ack` is high in the same cycle.
- If `rot_req` is still high at R1, the next rotation is issued from IDLE at R2 at the earliest.
- Asynchronous reset mid-SHIFT or mid-ROT forces the reset values immediately. A partially shifted byte is abandoned and the LUT may hold a partial table.

## Test plan
- Load bytes 0x11, 0x22, 0x33, 0x44 back-to-back with `in_valid` held high:
  - exactly 32 consecutive `lut_cs_n`-low cycles, `lut_d` = 0,0,0,1,0,0,0,1,…;
  - `done` pulses once, `loaded` = 1;
  - the LUT then reads sel 3/2/1/0 = 0x11/0x22/0x33/0x44.
- After that load, hold `rot_req` for one ack:
  - one `lut_rot_n` pulse, `rot_pos` = 1;
  - LUT sel 0 = 0x33, sel 3 = 0x44.
  - Four acked rotations return `rot_pos` to 0 and the original mapping.
- `rot_req` before any load, then after 2 of 4 bytes:
  - no `rot_ack` and no `lut_rot_n` pulse;
  - once the load completes, the pending request is acked.
- Assert `flush` after 2 bytes, with `in_valid` high on the same edge:
  - byte not accepted, `busy` = 0, `loaded` = 0;
  - a fresh 4-byte load then gives `done` after 32 more shift cycles.
- Assert `rst_n` = 0 at bit 4 of byte 2:
  - all outputs go to their reset values asynchronously;
  - after release, `in_ready` = 1, `rot_pos` = 0, and a full reload works.
- `in_valid` and `rot_req` both high in IDLE with `loaded` = 1:
  - the byte is accepted first;
  - the rotation is not acked until after that byte's SHIFT completes and the load reaches byte count 0.
